// File: rtl/fft_mag_writer_pkg.sv
// Shared types, widths and helpers for the FFT magnitude writer.
// Covers the FSM encoding, the sample payload layout and the alpha-max-beta-min shift constants.
package fft_mag_writer_pkg;

  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned COMP_W      = 16;
  localparam int unsigned MAG_W       = 15;
  localparam int unsigned DIN_W       = 16;
  localparam int unsigned MAG_SHIFT_A = 2;
  localparam int unsigned MAG_SHIFT_B = 3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [COMP_W-1:0] re;
    logic signed [COMP_W-1:0] im;
  } sample_t;

  // Absolute value clamped to 15 bits; the most negative input saturates to 0x7FFF.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [COMP_W-1:0] x);
    logic signed [COMP_W-1:0] neg;
    logic [MAG_W-1:0]         res;
    neg = -x;
    if (x == {1'b1, {(COMP_W-1){1'b0}}}) begin
      res = {MAG_W{1'b1}};
    end else if (x[COMP_W-1]) begin
      res = neg[MAG_W-1:0];
    end else begin
      res = x[MAG_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_mag_writer_mag_approx.sv
// Two-stage magnitude approximation: |re|,|im| then max + min/4 + min/8,
// carrying the bin address and a valid bit alongside the data.
module mag_approx
  import fft_mag_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  sample_t           sample_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DIN_W-1:0]  din_o
);

  logic              v1_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [MAG_W-1:0]  abs_re_q;
  logic [MAG_W-1:0]  abs_im_q;
  logic [MAG_W-1:0]  max_c;
  logic [MAG_W-1:0]  min_c;
  logic [DIN_W-1:0]  din_d;

  // Stage 1: saturating absolute values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      addr1_q  <= '0;
      abs_re_q <= '0;
      abs_im_q <= '0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        addr1_q  <= addr_i;
        abs_re_q <= sat_abs(sample_i.re);
        abs_im_q <= sat_abs(sample_i.im);
      end
    end
  end

  always_comb begin
    max_c = abs_re_q;
    min_c = abs_im_q;
    if (abs_im_q > abs_re_q) begin
      max_c = abs_im_q;
      min_c = abs_re_q;
    end
    din_d = DIN_W'(max_c) + DIN_W'(min_c >> MAG_SHIFT_A) + DIN_W'(min_c >> MAG_SHIFT_B);
  end

  // Stage 2: combined magnitude and BRAM write strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_o   <= 1'b0;
      addr_o <= '0;
      din_o  <= '0;
    end else begin
      we_o <= v1_q;
      if (v1_q) begin
        addr_o <= addr1_q;
        din_o  <= din_d;
      end
    end
  end

endmodule

// File: rtl/fft_mag_writer.sv
// Accepts one FFT frame per pass, writes per-bin magnitudes into BRAM port A,
// then flushes the pipeline and optionally waits for the reader before the next frame.
module fft_mag_writer
  import fft_mag_writer_pkg::*;
#(
  parameter int unsigned N_BINS        = 1024,
  parameter int unsigned ADDR_W        = 10,
  parameter bit          WAIT_CONSUMER = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  output logic [ADDR_W-1:0]   addr_a,
  output logic [DIN_W-1:0]    din_a,
  output logic                we_a,
  output logic                wubs_done,
  input  logic                fft_done,
  output logic                frame_err
);

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept_c;
  sample_t           sample_c;

  assign accept_c  = s_tvalid && ready_q;
  assign sample_c  = s_tdata;
  assign s_tready  = ready_q;
  assign wubs_done = done_q;
  assign frame_err = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Ready is registered from the next state so it matches FILL without a combinational path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          if (cnt_q == LAST_BIN) begin
            state_d = ST_FLUSH;
            flush_d = 1'b0;
            cnt_d   = '0;
            err_d   = !s_tlast;
          end else if (s_tlast) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        // Done is raised one cycle early so the registered pulse lands with the last write.
        if (flush_q) begin
          state_d = ST_HOLD;
        end else begin
          flush_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!WAIT_CONSUMER || fft_done) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_FILL);
  end

  mag_approx #(
    .ADDR_W (ADDR_W)
  ) u_mag (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid_i  (accept_c),
    .addr_i   (cnt_q),
    .sample_i (sample_c),
    .we_o     (we_a),
    .addr_o   (addr_a),
    .din_o    (din_a)
  );

endmodule

// File: doc/fft_mag_writer.md
FFT_MAG_WRITER -- requirements
Module: fft_mag_writer

Interface
REQ-001 Parameter: N_BINS, default 1024, number of FFT bins per frame (power of two).
REQ-002 Parameter: ADDR_W, default 10, equal to log2(N_BINS).
REQ-003 Parameter: WAIT_CONSUMER, default 1; 1 = hold off the next frame until the reader reports done, 0 = free-run.
REQ-004 Port: clock  in  1  single system clock; all logic is clocked on its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: s_tdata  in  32  FFT output sample; [31:16] signed real part, [15:0] signed imaginary part.
REQ-007 Port: s_tvalid  in  1  sample valid.
REQ-008 Port: s_tlast  in  1  marks the last sample of a frame.
REQ-009 Port: s_tready  out  1  block accepts a sample this cycle.
REQ-010 Port: addr_a  out  ADDR_W  magnitude BRAM write address (port A).
REQ-011 Port: din_a  out  16  unsigned magnitude write data.
REQ-012 Port: we_a  out  1  BRAM write enable.
REQ-013 Port: wubs_done  out  1  one-cycle pulse: a complete frame is in BRAM.
REQ-014 Port: fft_done  in  1  pulse or level from the BRAM reader: frame consumed.
REQ-015 Port: frame_err  out  1  one-cycle pulse: framing error detected.

Function
REQ-016 A sample SHALL be accepted only in a cycle where s_tvalid and s_tready are both 1.
REQ-017 FSM states SHALL be FILL, FLUSH and HOLD.
REQ-018 In FILL: s_tready=1; bin counter starts at 0 and increments once per accepted sample.
REQ-019 In FLUSH and HOLD: s_tready=0.
REQ-020 Stage 1 SHALL register abs(re) and abs(im), saturating -32768 to 32767 (15-bit unsigned).
REQ-021 Stage 2 SHALL register din_a = max + (min>>2) + (min>>3), zero-extended to 16 bits (fits without saturation), together with addr_a = that sample's bin index and we_a=1.
REQ-022 Latency: a sample accepted in cycle k SHALL produce we_a=1 in cycle k+2; we_a=0 in every other cycle.
REQ-023 Accepting the sample with bin index N_BINS-1 SHALL move the FSM FILL->FLUSH.
REQ-024 If that sample has s_tlast=0, frame_err SHALL pulse in the next cycle; the frame is still treated as complete.
REQ-025 s_tlast=1 at bin index < N_BINS-1 SHALL:
  - pulse frame_err in the next cycle;
  - reset the counter to 0 and stay in FILL;
  - leave wubs_done unpulsed (the writes already issued are not retracted).
REQ-026 FLUSH SHALL last exactly 2 cycles, pulse wubs_done in its final cycle, then go to HOLD.
  - wubs_done therefore coincides with the last we_a.
REQ-027 HOLD with WAIT_CONSUMER=1: leave for FILL (counter 0) on the first cycle fft_done=1.
  - fft_done seen in FILL or FLUSH SHALL be ignored.
REQ-028 HOLD with WAIT_CONSUMER=0: leave for FILL after 1 cycle.
REQ-029 fft_done and s_tvalid high together in HOLD: no sample accepted that cycle; acceptance starts the next cycle.
REQ-030 Bin counter SHALL wrap N_BINS-1 -> 0.

Reset
REQ-031 reset_n=0 SHALL immediately set:
  - state=FILL, counter=0;
  - pipeline valid bits 0;
  - we_a=0, wubs_done=0, frame_err=0, addr_a=0, din_a=0;
  - s_tready=0 while reset_n=0, becoming 1 from the first clock edge after release.
REQ-032 Reset mid-frame SHALL discard the partial frame, issue no further writes and no wubs_done.

Structure
REQ-033 The FSM state encoding and the magnitude-coefficient shift constants SHALL live in the shared project package.
REQ-034 The magnitude datapath (REQ-020, REQ-021) SHALL be a sub-module named mag_approx; FSM, counter and handshake stay in fft_mag_writer.

Verification
REQ-035 Single sample re=3, im=-4 at bin 0: we_a=1 two cycles after acceptance, addr_a=0, din_a=4+0+0=4.
REQ-036 re=-32768, im=-32768: din_a=32767+8191+4095=45053 (0xAFFD).
REQ-037 1024 samples, s_tlast on the 1024th:
  - 1024 writes at addresses 0..1023;
  - wubs_done single pulse with the last we_a;
  - s_tready=0 until fft_done is driven.
REQ-038 s_tlast on sample 100 (bin 99): frame_err pulse, no wubs_done; the next frame's first write goes to addr 0.
REQ-039 reset_n pulled low at bin 500 and released:
  - we_a=0 during reset;
  - the following full frame writes addresses 0..1023 and pulses wubs_done once.
REQ-040 WAIT_CONSUMER=0, back-to-back frames with continuous s_tvalid:
  - exactly 3 stall cycles (s_tready=0) between frames;
  - each frame pulses wubs_done.
